kitchen_timer_sequencer: RTL
============================

// Module: kitchen_timer_sequencer
// PURPOSE
//   Control/sequencing core for the kitchen timer. Takes user start/stop pulses and a
//   1/2/3-minute mode select, and owns the min:sec countdown. Derives a 1-second tick
//   from clk, raises the alarm at 0:00 and times the alarm duration.
//   Sits between the button debouncers and the display/buzzer drivers.
// PARAMETERS
//   TICK_DIV   50_000_000  clk cycles per second tick (>=2); bench uses 4
//   ALARM_SEC  10          seconds alarm stays asserted before auto-return to IDLE (>=1)
// PORTS
//   clk        in   1   system clock, all state updates on rising edge
//   rst        in   1   asynchronous, active-high reset
//   start      in   1   1-cycle pulse: start (IDLE), pause (RUN), resume (PAUSE)
//   stop       in   1   1-cycle pulse: abort to IDLE from any state
//   mode_sel   in   2   01=1 min, 10=2 min, 11=3 min, 00=invalid; sampled only on accepted start in IDLE
//   min_count  out  2   minutes remaining, 0..3
//   sec_count  out  6   seconds remaining, 0..59
//   running    out  1   1 while in RUN
//   paused     out  1   1 while in PAUSE
//   alarm      out  1   1 while in ALARM
//   done_pulse out  1   1-cycle pulse on the clock that enters ALARM
// BEHAVIOUR
//   Reset: state=IDLE; min_count=0, sec_count=0, prescaler=0, alarm counter=0; all outputs 0.
//   All outputs are registered. running/paused/alarm track the registered state.
//   States:
//   - IDLE:  start && mode_sel!=0 -> RUN, min_count<=mode_sel, sec_count<=0, prescaler<=0.
//            start with mode_sel==0 is ignored.
//   - RUN:   prescaler counts 0..TICK_DIV-1 and wraps; a tick occurs on the cycle prescaler==TICK_DIV-1.
//            On tick: if sec_count==0 then sec<=59, min<=min-1; else sec<=sec-1.
//            If the decremented value is 0:00 -> ALARM, done_pulse=1 that cycle, alarm counter<=0.
//            start -> PAUSE; prescaler and counts frozen.
//            stop -> IDLE; counts and prescaler cleared.
//   - PAUSE: counts and prescaler hold their values. start -> RUN, resuming from the held prescaler value.
//            stop -> IDLE; counts cleared.
//   - ALARM: counts hold 0:00. prescaler runs; each tick increments the alarm counter.
//            On the tick where it reaches ALARM_SEC -> IDLE.
//            stop -> IDLE at the next edge. start is ignored.
//   Priority: stop beats start in the same cycle, in every state.
//            In RUN, start/stop on a tick cycle take priority over the decrement.
//   Timing: first decrement occurs TICK_DIV cycles after the RUN entry edge.
//            Alarm asserts exactly mode*60*TICK_DIV cycles after the RUN entry edge (excluding paused cycles).
//   Counts never underflow: decrement happens only from a non-zero value, and 0:00 always leaves RUN.
//   Reset asserted mid-operation clears everything immediately (asynchronous), regardless of state.
//   Unreachable state encodings recover to IDLE.
// TESTING (TICK_DIV=4, ALARM_SEC=2)
//   1. Assert rst while in RUN at 1:23 -> immediately 0:00, running=0, alarm=0; remains IDLE after release.
//   2. mode_sel=01, start -> next edge 1:00, running=1. After 4 clk: 0:59.
//      After 240 clk from RUN entry: alarm=1, done_pulse=1 for exactly 1 cycle.
//      alarm stays high 8 clk, then IDLE.
//   3. mode_sel=11, start -> 3:00, first tick -> 2:59 (minute borrow). 1:00 -> 0:59 verified similarly.
//   4. In RUN at 0:57 with prescaler=2, pulse start -> paused=1; hold 20 clk with count 0:57 frozen.
//      Pulse start -> 0:56 exactly 2 clk after resume edge.
//   5. In RUN, start and stop on the same cycle -> IDLE next edge, 0:00, paused=0.
//   6. IDLE with mode_sel=00, start -> stays IDLE.
//      During ALARM, pulse stop -> alarm=0 next edge; start during ALARM has no effect.

Source files
------------

// File: rtl/kitchen_timer_sequencer.sv
// kitchen_timer_sequencer: start/pause/stop sequencing, min:sec countdown, 1 s prescaler and alarm timing.
module kitchen_timer_sequencer #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int ALARM_SEC = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] mode_sel,
  output logic [1:0] min_count,
  output logic [5:0] sec_count,
  output logic       running,
  output logic       paused,
  output logic       alarm,
  output logic       done_pulse
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int AW = $clog2(ALARM_SEC + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ACNT_MAX = AW'(ALARM_SEC - 1);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;
  state_t state_q, state_d;
  logic [1:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic [PW-1:0] pre_q, pre_d, pre_inc;
  logic [AW-1:0] acnt_q, acnt_d;
  logic running_q, running_d, paused_q, paused_d, alarm_q, alarm_d, done_q, done_d;
  logic tick;
  always_comb begin
    state_d = state_q;
    min_d = min_q;
    sec_d = sec_q;
    pre_d = pre_q;
    acnt_d = acnt_q;
    tick = pre_q == PRE_MAX;
    pre_inc = tick ? '0 : pre_q + PW'(1);
    case (state_q)
      IDLE: if (start && !stop && mode_sel != 2'd0) begin
        state_d = RUN;
        min_d = mode_sel;
        sec_d = '0;
        pre_d = '0;
      end
      RUN: if (stop) begin
        state_d = IDLE;
        min_d = '0;
        sec_d = '0;
        pre_d = '0;
      end else if (start) begin
        state_d = PAUSE;
      end else begin
        pre_d = pre_inc;
        if (tick) begin
          sec_d = sec_q == 6'd0 ? 6'd59 : sec_q - 6'd1;
          min_d = sec_q == 6'd0 ? min_q - 2'd1 : min_q;
          // Only 0:01 can decrement to 0:00, so that is the sole alarm entry.
          if (min_q == 2'd0 && sec_q == 6'd1) begin
            state_d = ALARM;
            acnt_d = '0;
          end
        end
      end
      PAUSE: if (stop) begin
        state_d = IDLE;
        min_d = '0;
        sec_d = '0;
        pre_d = '0;
      end else if (start) begin
        state_d = RUN;
      end
      ALARM: if (stop) begin
        state_d = IDLE;
        pre_d = '0;
        acnt_d = '0;
      end else begin
        pre_d = pre_inc;
        if (tick) begin
          acnt_d = acnt_q + AW'(1);
          if (acnt_q == ACNT_MAX) begin
            state_d = IDLE;
            pre_d = '0;
            acnt_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        min_d = '0;
        sec_d = '0;
        pre_d = '0;
        acnt_d = '0;
      end
    endcase
    running_d = state_d == RUN;
    paused_d = state_d == PAUSE;
    alarm_d = state_d == ALARM;
    done_d = state_q == RUN && state_d == ALARM;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      min_q <= '0;
      sec_q <= '0;
      pre_q <= '0;
      acnt_q <= '0;
      running_q <= 1'b0;
      paused_q <= 1'b0;
      alarm_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q <= min_d;
      sec_q <= sec_d;
      pre_q <= pre_d;
      acnt_q <= acnt_d;
      running_q <= running_d;
      paused_q <= paused_d;
      alarm_q <= alarm_d;
      done_q <= done_d;
    end
  end
  assign min_count = min_q;
  assign sec_count = sec_q;
  assign running = running_q;
  assign paused = paused_q;
  assign alarm = alarm_q;
  assign done_pulse = done_q;
endmodule
